// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART receiver/transmitter state encoding and oversampling constants
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } uart_state_t;

  localparam int         OVERSAMPLE = 16;
  localparam logic [3:0] SAMPLE_LO  = 4'd7;
  localparam logic [3:0] SAMPLE_MID = 4'd8;
  localparam logic [3:0] SAMPLE_HI  = 4'd9;
  localparam int         DATA_BITS  = 8;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - fractional accumulator producing one-cycle 16x-baud oversampling ticks
module uart_baud_tick #(
  parameter int unsigned clock_frequency = 100000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] baud_rate,
  output logic        tick
);
  import uart_pkg::*;

  localparam logic [39:0] CLK_FREQ = 40'(clock_frequency);

  logic [39:0] r_acc;
  logic        r_tick;
  logic [39:0] w_inc;
  logic [39:0] w_sum;

  // Held at 40 bits so baud_rate*16 plus the residue never wraps.
  assign w_inc = 40'(baud_rate) * 40'(OVERSAMPLE);
  assign w_sum = r_acc + w_inc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc  <= '0;
      r_tick <= 1'b0;
    end else if (w_sum >= CLK_FREQ) begin
      r_acc  <= w_sum - CLK_FREQ;
      r_tick <= 1'b1;
    end else begin
      r_acc  <= w_sum;
      r_tick <= 1'b0;
    end
  end

  assign tick = r_tick;

endmodule

// File: rtl/uart_rx_oversample.sv
// rtl/uart_rx_oversample.sv - 16x oversampling majority-vote UART receiver, 8N1 (8E1 with UART_PARITY_EN)
module uart_rx_oversample #(
  parameter int unsigned clock_frequency = 100000000,
  parameter int unsigned OVERSAMPLE      = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] baud_rate,
  input  logic        rx_in,
  output logic [7:0]  data_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        frame_err,
  output logic        overrun,
  output logic        parity_err,
  output logic        busy
);
  import uart_pkg::*;

  logic        r_sync1;
  logic        r_sync2;
  uart_state_t r_state;
  uart_state_t w_next;
  logic [3:0]  r_sc;
  logic [2:0]  r_bit_idx;
  logic [7:0]  r_shift;
  logic        r_s_lo;
  logic        r_s_mid;
  logic [7:0]  r_data;
  logic        r_valid;
  logic        r_frame_err;
  logic        r_overrun;

  logic w_tick;
  logic w_vote;
  logic w_vote_tick;
  logic w_last_tick;
  logic w_start;
  logic w_shift_en;
  logic w_bit_adv;
  logic w_done;
  logic w_ferr;
`ifdef UART_PARITY_EN
  logic r_par;
  logic r_parity_err;
  logic w_par_en;
  logic w_perr;
`endif

  uart_baud_tick #(
    .clock_frequency(clock_frequency)
  ) u_baud_tick (
    .clk      (clk),
    .reset    (reset),
    .baud_rate(baud_rate),
    .tick     (w_tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_vote      = majority3(r_s_lo, r_s_mid, r_sync2);
  assign w_vote_tick = w_tick && (r_sc == SAMPLE_HI);
  assign w_last_tick = w_tick && (r_sc == 4'(OVERSAMPLE - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_start    = 1'b0;
    w_shift_en = 1'b0;
    w_bit_adv  = 1'b0;
    w_done     = 1'b0;
    w_ferr     = 1'b0;
`ifdef UART_PARITY_EN
    w_par_en   = 1'b0;
    w_perr     = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        // Without a baud rate no ticks arrive, so never leave IDLE.
        if (!r_sync2 && (baud_rate != '0)) begin
          w_next  = START;
          w_start = 1'b1;
        end
      end
      START: begin
        if (w_vote_tick && w_vote) begin
          w_next = IDLE;
        end else if (w_last_tick) begin
          w_next = DATA;
        end
      end
      DATA: begin
        w_shift_en = w_vote_tick;
        if (w_last_tick) begin
          if (r_bit_idx == 3'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
            w_next = PARITY;
`else
            w_next = STOP;
`endif
          end else begin
            w_bit_adv = 1'b1;
          end
        end
      end
`ifdef UART_PARITY_EN
      PARITY: begin
        w_par_en = w_vote_tick;
        if (w_last_tick) begin
          w_next = STOP;
        end
      end
`endif
      STOP: begin
        // Leave at the mid-bit vote rather than sc=15 to gain resync margin.
        if (w_vote_tick) begin
          if (w_vote) begin
`ifdef UART_PARITY_EN
            if ((^r_shift) != r_par) begin
              w_perr = 1'b1;
            end else begin
              w_done = 1'b1;
            end
`else
            w_done = 1'b1;
`endif
            w_next = IDLE;
          end else begin
            w_ferr = 1'b1;
            w_next = BREAK;
          end
        end
      end
      BREAK: begin
        if (r_sync2) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sc      <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_s_lo    <= 1'b1;
      r_s_mid   <= 1'b1;
`ifdef UART_PARITY_EN
      r_par     <= 1'b0;
`endif
    end else begin
      if (w_start) begin
        r_sc <= '0;
      end else if (w_tick && (r_state != IDLE)) begin
        r_sc <= r_sc + 4'd1;
      end
      if (w_tick && (r_sc == SAMPLE_LO)) begin
        r_s_lo <= r_sync2;
      end
      if (w_tick && (r_sc == SAMPLE_MID)) begin
        r_s_mid <= r_sync2;
      end
      if (w_start) begin
        r_bit_idx <= '0;
      end else if (w_bit_adv) begin
        r_bit_idx <= r_bit_idx + 3'd1;
      end
      if (w_shift_en) begin
        r_shift <= {w_vote, r_shift[7:1]};
      end
`ifdef UART_PARITY_EN
      if (w_par_en) begin
        r_par <= w_vote;
      end
`endif
    end
  end

  // Holding register runs independently of the FSM; a full register drops the new byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_ferr;
      r_overrun   <= 1'b0;
      if (w_done && (!r_valid || out_ready)) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
      end else if (w_done) begin
        r_overrun <= 1'b1;
      end else if (r_valid && out_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

`ifdef UART_PARITY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_parity_err <= 1'b0;
    end else begin
      r_parity_err <= w_perr;
    end
  end
  assign parity_err = r_parity_err;
`else
  assign parity_err = 1'b0;
`endif

  assign data_out  = r_data;
  assign out_valid = r_valid;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx_oversample.sv
// tb/tb_uart_rx_oversample.sv - self-checking bench for uart_rx_oversample
module tb_uart_rx_oversample;

  localparam int unsigned CLK_HZ  = 1600000;
  localparam int          BIT_CLK = 160;
`ifdef UART_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] baud_rate;
  logic        rx_in;
  logic [7:0]  data_out;
  logic        out_valid;
  logic        out_ready;
  logic        frame_err;
  logic        overrun;
  logic        parity_err;
  logic        busy;

  always #5 clk = ~clk;

  uart_rx_oversample #(.clock_frequency(CLK_HZ)) dut (
    .clk       (clk),
    .reset     (reset),
    .baud_rate (baud_rate),
    .rx_in     (rx_in),
    .data_out  (data_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .parity_err(parity_err),
    .busy      (busy)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int t_start  = 0;
  int t_valid  = 0;
  int n_ferr, n_ovr, n_perr, n_valid_cyc;
  logic prev_valid = 1'b0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] data;
    bit         stop;
    int         exp_out;
    int         exp_ferr;
  } vec_t;
  vec_t tbl[6];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (out_valid && !prev_valid) t_valid = cyc;
    prev_valid = out_valid;
    if (out_valid) n_valid_cyc++;
    if (out_valid && out_ready) got_q.push_back(data_out);
    if (frame_err) n_ferr++;
    if (overrun) n_ovr++;
    if (parity_err) n_perr++;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr();
    got_q.delete();
    n_ferr = 0;
    n_ovr = 0;
    n_perr = 0;
    n_valid_cyc = 0;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop, input bit par_bad, input int spike_bit);
    rx_in = 1'b0;
    t_start = cyc;
    wait_clk(BIT_CLK);
    for (int i = 0; i < 8; i++) begin
      rx_in = d[i];
      if (i == spike_bit) begin
        wait_clk(88);
        rx_in = ~d[i];
        wait_clk(1);
        rx_in = d[i];
        wait_clk(BIT_CLK - 89);
      end else begin
        wait_clk(BIT_CLK);
      end
    end
    if (PAR_EN) begin
      rx_in = (^d) ^ par_bad;
      wait_clk(BIT_CLK);
    end
    rx_in = stop;
    wait_clk(BIT_CLK);
  endtask

  initial begin
    #9_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit   st;
    bit   pb;
    logic [7:0] d;
    int   exp_ferr;
    int   exp_perr;

    tbl[0] = '{8'h00, 1'b1, 1, 0};
    tbl[1] = '{8'hFF, 1'b1, 1, 0};
    tbl[2] = '{8'h5A, 1'b1, 1, 0};
    tbl[3] = '{8'h80, 1'b0, 0, 1};
    tbl[4] = '{8'h01, 1'b1, 1, 0};
    tbl[5] = '{8'hC3, 1'b0, 0, 1};

    reset = 1'b1;
    rx_in = 1'b1;
    out_ready = 1'b1;
    baud_rate = 32'd10000;
    clr();
    wait_clk(5);
    check("reset_outputs", {24'd0, data_out}, 32'd0);
    check("reset_flags", {27'd0, out_valid, frame_err, overrun, parity_err, busy}, 32'd0);
    reset = 1'b0;
    wait_clk(50);

    // Basic frame with latency window
    clr();
    send_frame(8'hA5, 1'b1, 1'b0, -1);
    wait_clk(100);
    check("a5_count", got_q.size(), 1);
    if (got_q.size() == 1) check("a5_data", got_q[0], 8'hA5);
    check("a5_valid_cycles", n_valid_cyc, 1);
    check("a5_latency_ok", ((t_valid - t_start) >= 1400 + (PAR_EN ? BIT_CLK : 0)) &&
                           ((t_valid - t_start) <= 1620 + (PAR_EN ? BIT_CLK : 0)), 1);
    check("a5_flags", n_ferr + n_ovr + n_perr, 0);

    // Glitch on idle line
    clr();
    rx_in = 1'b0;
    wait_clk(30);
    rx_in = 1'b1;
    wait_clk(400);
    check("glitch_busy", busy, 0);
    check("glitch_nothing", got_q.size() + n_ferr + n_ovr + n_perr, 0);

    // Bad stop, line held low, then recovery
    clr();
    send_frame(8'h3C, 1'b0, 1'b0, -1);
    wait_clk(2000);
    check("break_ferr_once", n_ferr, 1);
    check("break_no_out", got_q.size(), 0);
    check("break_busy", busy, 1);
    rx_in = 1'b1;
    wait_clk(20);
    check("break_exit", busy, 0);
    send_frame(8'h81, 1'b1, 1'b0, -1);
    wait_clk(100);
    check("after_break_count", got_q.size(), 1);
    if (got_q.size() == 1) check("after_break_data", got_q[0], 8'h81);

    // Table-driven frames
    for (int v = 0; v < 6; v++) begin
      clr();
      send_frame(tbl[v].data, tbl[v].stop, 1'b0, -1);
      rx_in = 1'b1;
      wait_clk(100);
      check($sformatf("tbl%0d_count", v), got_q.size(), tbl[v].exp_out);
      if (tbl[v].exp_out == 1 && got_q.size() == 1) check($sformatf("tbl%0d_data", v), got_q[0], tbl[v].data);
      check($sformatf("tbl%0d_ferr", v), n_ferr, tbl[v].exp_ferr);
      check($sformatf("tbl%0d_perr", v), n_perr, 0);
    end

    // Overrun: consumer stalled across two frames
    clr();
    out_ready = 1'b0;
    send_frame(8'h11, 1'b1, 1'b0, -1);
    send_frame(8'h22, 1'b1, 1'b0, -1);
    wait_clk(50);
    check("ovr_count", n_ovr, 1);
    check("ovr_held_data", data_out, 8'h11);
    check("ovr_held_valid", out_valid, 1);
    check("ovr_no_xfer", got_q.size(), 0);
    out_ready = 1'b1;
    wait_clk(10);
    check("ovr_one_xfer", got_q.size(), 1);
    if (got_q.size() == 1) check("ovr_xfer_data", got_q[0], 8'h11);
    check("ovr_valid_clear", out_valid, 0);

    // Single-clock noise spike mid-bit
    clr();
    send_frame(8'hF0, 1'b1, 1'b0, 4);
    wait_clk(100);
    check("spike_count", got_q.size(), 1);
    if (got_q.size() == 1) check("spike_data", got_q[0], 8'hF0);

    // Reset in the middle of a data bit
    clr();
    d = 8'h55;
    rx_in = 1'b0;
    wait_clk(BIT_CLK);
    for (int i = 0; i < 3; i++) begin
      rx_in = d[i];
      wait_clk(BIT_CLK);
    end
    rx_in = d[3];
    wait_clk(80);
    reset = 1'b1;
    #1;
    check("midreset_data", data_out, 8'h00);
    check("midreset_flags", {out_valid, frame_err, overrun, parity_err, busy}, 5'b0);
    rx_in = 1'b1;
    wait_clk(3);
    reset = 1'b0;
    wait_clk(300);
    check("midreset_no_partial", got_q.size(), 0);
    send_frame(8'h0F, 1'b1, 1'b0, -1);
    wait_clk(100);
    check("midreset_next_count", got_q.size(), 1);
    if (got_q.size() == 1) check("midreset_next_data", got_q[0], 8'h0F);

`ifdef UART_PARITY_EN
    clr();
    send_frame(8'h07, 1'b1, 1'b1, -1);
    wait_clk(100);
    check("par_err_pulse", n_perr, 1);
    check("par_no_out", got_q.size(), 0);
    clr();
    send_frame(8'h07, 1'b0, 1'b1, -1);
    rx_in = 1'b1;
    wait_clk(100);
    check("par_ferr_wins_f", n_ferr, 1);
    check("par_ferr_wins_p", n_perr, 0);
`endif

    // Randomized frames against the frame-rule model
    clr();
    exp_q.delete();
    exp_ferr = 0;
    exp_perr = 0;
    for (int k = 0; k < 12; k++) begin
      d  = 8'($urandom_range(0, 255));
      st = ($urandom_range(0, 7) != 0);
      pb = PAR_EN ? ($urandom_range(0, 4) == 0) : 1'b0;
      wait_clk($urandom_range(1, 40));
      send_frame(d, st, pb, -1);
      rx_in = 1'b1;
      if (!st) exp_ferr++;
      else if (pb) exp_perr++;
      else exp_q.push_back(d);
    end
    wait_clk(100);
    check("rand_count", got_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
      check($sformatf("rand_data%0d", k), got_q[k], exp_q[k]);
    check("rand_ferr", n_ferr, exp_ferr);
    check("rand_perr", n_perr, exp_perr);
    check("rand_ovr", n_ovr, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
